host_seq: RTL and testbench

Host-side job sequencer for the single-cycle core: the initiator end of the core's `req`/`done` handshake. Per job it streams input words into data memory, pulses `core_req`, and waits for `core_done` under a cycle timeout. It then streams a result window of data memory back out. It owns the data-memory port except while the core runs.

---
 rtl/host_seq_pkg.sv | 15 +
 rtl/seq_run_timer.sv | 34 +++
 rtl/host_seq.sv | 141 ++++++++++++++
 tb/tb_host_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_seq_pkg.sv
// Shared types and defaults for the host job sequencer.
package host_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/seq_run_timer.sv
// RUN-phase cycle counter: clears on clr, counts on en; expired flags the enabled cycle that reaches TIMEOUT.
// Zero latency on expired (combinational from count/en); no backpressure.
module seq_run_timer
  import host_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count,
  output logic        expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] count_nxt;

  assign count_nxt = count + 16'd1;
  // Asserted during the cycle whose increment lands on LIMIT, so count ends exactly at TIMEOUT.
  assign expired   = en && (count_nxt == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (en) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/host_seq.sv
// Host job sequencer: load words into dat_mem, pulse core_req, wait done/timeout, stream result window out.
// start->in_ready 1 cycle, done->out_valid 1 cycle; both streams valid/ready at one word per cycle.
module host_seq
  import host_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  load_base,
  input  logic [7:0]  load_cnt,
  input  logic [7:0]  res_base,
  input  logic [7:0]  res_cnt,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        mem_sel,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wr_en,
  input  logic [7:0]  mem_rdata,
  output logic        core_req,
  input  logic        core_done,
  output logic        busy,
  output logic        error,
  output logic [15:0] cycles,
  output logic        job_done
);

  state_t      state, state_nxt;
  logic [7:0]  idx;
  logic [7:0]  load_base_q, load_cnt_q, res_base_q, res_cnt_q;
  logic        error_q;
  logic        load_fire, drain_fire, done_seen;
  logic        tmr_clr, tmr_en, tmr_exp;
  logic [15:0] tmr_count;

  seq_run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .count   (tmr_count),
    .expired (tmr_exp)
  );

  assign tmr_clr    = (state == S_REQ);
  assign tmr_en     = (state == S_RUN);
  assign load_fire  = (state == S_LOAD) && in_valid;
  assign drain_fire = (state == S_DRAIN) && out_ready;
  // The first RUN cycle (count still 0) blanks a done left high by the previous job.
  assign done_seen  = core_done && (tmr_count != 16'd0);

  assign busy     = (state != S_IDLE);
  assign error    = error_q;
  assign cycles   = tmr_count;
  assign out_data = mem_rdata;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_sel   = 1'b1;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    mem_wr_en = 1'b0;
    core_req  = 1'b0;
    job_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = (load_cnt != 8'd0) ? S_LOAD : S_REQ;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (load_fire) begin
          mem_wr_en = 1'b1;
          mem_addr  = load_base_q + idx;
          mem_wdata = in_data;
          if (idx == load_cnt_q - 8'd1) state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_sel   = 1'b0;
        core_req  = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        mem_sel = 1'b0;
        // Done beats a simultaneous timeout.
        if (done_seen)    state_nxt = (res_cnt_q != 8'd0) ? S_DRAIN : S_FIN;
        else if (tmr_exp) state_nxt = S_FIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        mem_addr  = res_base_q + idx;
        if (drain_fire && (idx == res_cnt_q - 8'd1)) state_nxt = S_FIN;
      end
      S_FIN: begin
        job_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= 8'd0;
      load_base_q <= 8'd0;
      load_cnt_q  <= 8'd0;
      res_base_q  <= 8'd0;
      res_cnt_q   <= 8'd0;
      error_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            load_base_q <= load_base;
            load_cnt_q  <= load_cnt;
            res_base_q  <= res_base;
            res_cnt_q   <= res_cnt;
            error_q     <= 1'b0;
            idx         <= 8'd0;
          end
        end
        S_LOAD:  if (load_fire) idx <= idx + 8'd1;
        S_REQ:   idx <= 8'd0;
        S_RUN:   if (tmr_exp && !done_seen) error_q <= 1'b1;
        S_DRAIN: if (drain_fire) idx <= idx + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_host_seq.sv
// Bench for host_seq: two instances (TIMEOUT 4096 and 16) share stimulus; a job-level model is checked every cycle.
module tb_host_seq;

  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_REQ = 2, PH_RUN = 3, PH_DRAIN = 4, PH_FIN = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, in_valid, out_ready, core_done;
  logic [7:0] load_base, load_cnt, res_base, res_cnt, in_data;

  logic [1:0]  in_ready_o, out_valid_o, mem_sel_o, mem_wr_en_o, core_req_o, busy_o, error_o, job_done_o;
  logic [7:0]  out_data_o [2];
  logic [7:0]  mem_addr_o [2];
  logic [7:0]  mem_wdata_o [2];
  logic [7:0]  rdata [2];
  logic [15:0] cycles_o [2];

  logic [7:0] mem [256];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    host_seq #(.TIMEOUT(g == 0 ? 4096 : 16)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .start     (start),
      .load_base (load_base),
      .load_cnt  (load_cnt),
      .res_base  (res_base),
      .res_cnt   (res_cnt),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready_o[g]),
      .out_valid (out_valid_o[g]),
      .out_data  (out_data_o[g]),
      .out_ready (out_ready),
      .mem_sel   (mem_sel_o[g]),
      .mem_addr  (mem_addr_o[g]),
      .mem_wdata (mem_wdata_o[g]),
      .mem_wr_en (mem_wr_en_o[g]),
      .mem_rdata (rdata[g]),
      .core_req  (core_req_o[g]),
      .core_done (core_done),
      .busy      (busy_o[g]),
      .error     (error_o[g]),
      .cycles    (cycles_o[g]),
      .job_done  (job_done_o[g])
    );
    assign rdata[g] = mem[mem_addr_o[g]];
  end

  int checks = 0;
  int failures = 0;

  // ---- job-level model: phase of the current job, words moved, RUN cycles elapsed ----
  int m_ph [2]  = '{PH_IDLE, PH_IDLE};
  int m_idx [2] = '{0, 0};
  int m_cyc [2] = '{0, 0};
  bit m_err [2] = '{1'b0, 1'b0};
  int m_lb [2]  = '{0, 0};
  int m_lc [2]  = '{0, 0};
  int m_rb [2]  = '{0, 0};
  int m_rc [2]  = '{0, 0};

  function automatic int tmo_of(input int i);
    return (i == 0) ? 4096 : 16;
  endfunction

  task automatic model_reset(input int i);
    m_ph[i] = PH_IDLE; m_idx[i] = 0; m_cyc[i] = 0; m_err[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    case (m_ph[i])
      PH_IDLE: if (start) begin
        m_lb[i] = load_base; m_lc[i] = load_cnt; m_rb[i] = res_base; m_rc[i] = res_cnt;
        m_err[i] = 1'b0; m_idx[i] = 0;
        m_ph[i] = (load_cnt != 0) ? PH_LOAD : PH_REQ;
      end
      PH_LOAD: if (in_valid) begin
        m_idx[i] = m_idx[i] + 1;
        if (m_idx[i] == m_lc[i]) m_ph[i] = PH_REQ;
      end
      PH_REQ: begin
        m_cyc[i] = 0; m_idx[i] = 0; m_ph[i] = PH_RUN;
      end
      PH_RUN: begin
        m_cyc[i] = m_cyc[i] + 1;
        if (m_cyc[i] > 1 && core_done) m_ph[i] = (m_rc[i] != 0) ? PH_DRAIN : PH_FIN;
        else if (m_cyc[i] == tmo_of(i)) begin m_err[i] = 1'b1; m_ph[i] = PH_FIN; end
      end
      PH_DRAIN: if (out_ready) begin
        m_idx[i] = m_idx[i] + 1;
        if (m_idx[i] == m_rc[i]) m_ph[i] = PH_FIN;
      end
      default: m_ph[i] = PH_IDLE;
    endcase
  endtask

  // {in_ready,out_valid,wr_en,mem_sel,core_req,busy,error,job_done, addr, wdata, cycles, out_data}
  function automatic logic [47:0] exp_vec(input int i);
    logic ir, ov, we;
    logic [7:0] a, wd, od;
    ir = (m_ph[i] == PH_LOAD);
    ov = (m_ph[i] == PH_DRAIN);
    we = ir && in_valid;
    a = 8'd0; wd = 8'd0; od = 8'd0;
    if (we) begin a = 8'(m_lb[i] + m_idx[i]); wd = in_data; end
    if (ov) begin a = 8'(m_rb[i] + m_idx[i]); od = mem[a]; end
    return {ir, ov, we, !(m_ph[i] == PH_REQ || m_ph[i] == PH_RUN), m_ph[i] == PH_REQ,
            m_ph[i] != PH_IDLE, m_err[i], m_ph[i] == PH_FIN, a, wd, 16'(m_cyc[i]), od};
  endfunction

  function automatic logic [47:0] act_vec(input int i, input logic ov_e, input logic we_e);
    return {in_ready_o[i], out_valid_o[i], mem_wr_en_o[i], mem_sel_o[i], core_req_o[i],
            busy_o[i], error_o[i], job_done_o[i],
            (we_e || ov_e) ? mem_addr_o[i] : 8'd0, we_e ? mem_wdata_o[i] : 8'd0,
            cycles_o[i], ov_e ? out_data_o[i] : 8'd0};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      else        model_step(i);
    end
  end

  // ---- per-cycle compare plus event logs for the directed checks ----
  logic [15:0] wlog [$];
  logic [7:0]  olog [$];
  int creq_cnt = 0, ov0_cnt = 0, ov1_cnt = 0, jd1_cnt = 0;

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic [47:0] e, a;
      e = exp_vec(i);
      a = act_vec(i, e[46], e[45]);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outs_dut%0d t=%0t got=%h exp=%h", i, $time, a, e);
      end
    end
    if (rst_n) begin
      if (mem_wr_en_o[0]) wlog.push_back({mem_addr_o[0], mem_wdata_o[0]});
      if (core_req_o[0])  creq_cnt++;
      if (out_valid_o[0]) begin olog.push_back(out_data_o[0]); ov0_cnt++; end
      if (out_valid_o[1]) ov1_cnt++;
      if (job_done_o[1])  jd1_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] lb, input logic [7:0] lc, input logic [7:0] rb, input logic [7:0] rc);
    load_base = lb; load_cnt = lc; res_base = rb; res_cnt = rc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; core_done = 1'b0;
    load_base = 8'd0; load_cnt = 8'd0; res_base = 8'd0; res_cnt = 8'd0; in_data = 8'd0;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k ^ 8'h99);
    mem[8'h40] = 8'h5A;
    mem[8'h41] = 8'h3C;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_flags", {in_ready_o[0], out_valid_o[0], mem_wr_en_o[0], core_req_o[0], busy_o[0], error_o[0], job_done_o[0]}, 32'd0);
    chk("rst_mem_sel", mem_sel_o[0], 32'd1);
    chk("rst_addr_wdata", {mem_addr_o[0], mem_wdata_o[0]}, 32'd0);
    chk("rst_cycles", cycles_o[0], 32'd0);
    rst_n = 1'b1;
    tick();

    // job 1: nothing to load or read back
    start_job(8'h00, 8'h00, 8'h00, 8'h00);
    chk("j1_core_req_cycle2", core_req_o[0], 32'd1);
    tick(); tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("j1_job_done", job_done_o[0], 32'd1);
    chk("j1_cycles", cycles_o[0], 32'd2);
    tick();

    // job 2: three words with gaps, done left high afterwards
    wlog.delete(); creq_cnt = 0;
    start_job(8'h10, 8'd3, 8'h00, 8'h00);
    in_valid = 1'b1; in_data = 8'hA1; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'hB2; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'hC3; tick();
    in_valid = 1'b0;
    chk("j2_req_after_last", core_req_o[0], 32'd1);
    repeat (5) tick();
    core_done = 1'b1;
    tick(); tick();
    chk("j2_wr_count", wlog.size(), 32'd3);
    chk("j2_wr0", wlog[0], 32'h10A1);
    chk("j2_wr1", wlog[1], 32'h11B2);
    chk("j2_wr2", wlog[2], 32'h12C3);
    chk("j2_req_pulses", creq_cnt, 32'd1);
    chk("j2_cycles", cycles_o[0], 32'd5);

    // job 3: stale done blanked, done on RUN cycle 20, stalled readback
    olog.delete();
    start_job(8'h00, 8'h00, 8'h40, 8'd2);
    tick();
    tick();
    core_done = 1'b0;
    repeat (18) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("j3_first_valid", {out_valid_o[0], out_data_o[0]}, 32'h15A);
    tick(); tick(); tick();
    out_ready = 1'b1;
    tick(); tick();
    chk("j3_job_done", job_done_o[0], 32'd1);
    chk("j3_cycles", cycles_o[0], 32'd20);
    chk("j3_to_error", error_o[1], 32'd1);
    chk("j3_out_count", olog.size(), 32'd5);
    chk("j3_out_stall", {olog[0], olog[1], olog[2], olog[3]}, 32'h5A5A5A5A);
    chk("j3_out_last", olog[4], 32'h3C);
    tick();

    // job 4: small-timeout instance expires, large one gets done on RUN cycle 30
    ov1_cnt = 0; jd1_cnt = 0;
    start_job(8'h00, 8'h00, 8'h40, 8'd2);
    tick();
    repeat (29) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick(); tick();
    chk("j4_job_done", job_done_o[0], 32'd1);
    chk("j4_cycles", cycles_o[0], 32'd30);
    chk("j4_error", error_o[0], 32'd0);
    chk("to_error", error_o[1], 32'd1);
    chk("to_cycles", cycles_o[1], 32'd16);
    chk("to_no_valid", ov1_cnt, 32'd0);
    chk("to_job_done_pulses", jd1_cnt, 32'd1);
    tick();
    start_job(8'h00, 8'h00, 8'h00, 8'h00);
    chk("to_error_cleared", error_o[1], 32'd0);
    tick(); tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();

    // job 5: load address wraps past 0xFF
    wlog.delete();
    start_job(8'hFE, 8'd4, 8'h00, 8'h00);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(k + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("wrap_w0", wlog[0], 32'hFE01);
    chk("wrap_w1", wlog[1], 32'hFF02);
    chk("wrap_w2", wlog[2], 32'h0003);
    chk("wrap_w3", wlog[3], 32'h0104);
    tick(); tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();

    // job 6: asynchronous reset after two of four words
    start_job(8'h20, 8'd4, 8'h00, 8'h00);
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready_o[0], 32'd0);
    chk("arst_idle", {busy_o[0], mem_sel_o[0]}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // job 7: start during RUN is ignored
    ov0_cnt = 0;
    start_job(8'h00, 8'h00, 8'h00, 8'h00);
    tick(); tick(); tick();
    load_cnt = 8'd5; res_cnt = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("j7_job_done", job_done_o[0], 32'd1);
    chk("j7_cycles", cycles_o[0], 32'd8);
    tick();
    chk("j7_idle", busy_o[0], 32'd0);
    chk("j7_no_readback", ov0_cnt, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
